turbo_encoder: RTL

- Rate-1/3 turbo encoder: two identical recursive systematic convolutional (RSC) constituent encoders with a fixed 5-entry interleaver, trellis-terminated to 7 symbols per stream.
- Consumes one 5-bit message per start and produces one 21-bit codeword {systematic, parity1, parity2}.
- Codeword layout is exactly the 21-bit block format expected by the turbo decoder's `data_i`, so this block sits at the transmit end of the same link; it is also the bench's golden stimulus source.

---
 rtl/turbo_encoder.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/turbo_encoder.sv
// Rate-1/3 turbo encoder: two 7/5 RSC constituents and a fixed 5-entry
// interleaver. Each stream is trellis-terminated with 2 tail symbols.
//
// Ports:
//   clk_p_i      clock, rising edge
//   reset_n_i    asynchronous active-low reset
//   data_i[4:0]  message, d0 = data_i[4]
//   start_i      request, sampled only in IDLE
//   busy_o       high whenever the encoder is not IDLE
//   data_o[20:0] codeword {sys[6:0], p1[6:0], p2[6:0]}, symbol 0 is the MSB
//   done_o       one-cycle pulse marking data_o valid
//   frame_cnt_o  completed-codeword count (only with TURBO_ENC_FRAME_CNT_EN)
//
// Optional feature macro: TURBO_ENC_FRAME_CNT_EN.
module turbo_encoder (
  input  logic        clk_p_i,
  input  logic        reset_n_i,
  input  logic [4:0]  data_i,
  input  logic        start_i,
  output logic        busy_o,
  output logic [20:0] data_o,
  output logic        done_o
`ifdef TURBO_ENC_FRAME_CNT_EN
  ,
  output logic [7:0]  frame_cnt_o
`endif
);

  localparam int unsigned INPUT_SIZE  = 5;
  localparam int unsigned EXTEND_SIZE = INPUT_SIZE + 2;
  localparam int unsigned CW_W        = 3 * EXTEND_SIZE;
  localparam int unsigned IDX_W       = 3;

  typedef enum logic [1:0] {S_IDLE, S_ENC, S_TAIL, S_DONE} state_e;

  state_e                   state_q, state_d;
  logic [IDX_W-1:0]         idx_q, idx_d;
  logic [INPUT_SIZE-1:0]    msg_q, msg_d;
  logic [1:0]               r1_q, r1_d;   // RSC1 {s1, s2}
  logic [1:0]               r2_q, r2_d;   // RSC2 {s1, s2}
  logic [EXTEND_SIZE-1:0]   sys_q, sys_d;
  logic [EXTEND_SIZE-1:0]   p1_q, p1_d;
  logic [EXTEND_SIZE-1:0]   p2_q, p2_d;
  logic [CW_W-1:0]          data_q, data_d;
  logic                     done_q, done_d;
  logic                     busy_q, busy_d;
`ifdef TURBO_ENC_FRAME_CNT_EN
  logic [7:0]               cnt_q, cnt_d;
`endif

  logic step;
  logic u1, u2, a1, a2, par1, par2;

  // Interleaver: RSC2 sees d_pi(k) at step k.
  function automatic logic [IDX_W-1:0] pi_f(input logic [IDX_W-1:0] k);
    case (k)
      3'd0:    pi_f = 3'd0;
      3'd1:    pi_f = 3'd4;
      3'd2:    pi_f = 3'd2;
      3'd3:    pi_f = 3'd1;
      3'd4:    pi_f = 3'd3;
      default: pi_f = 3'd0;
    endcase
  endfunction

  // Next-state, trellis step and output register inputs.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    msg_d   = msg_q;
    r1_d    = r1_q;
    r2_d    = r2_q;
    sys_d   = sys_q;
    p1_d    = p1_q;
    p2_d    = p2_q;
    data_d  = data_q;
    step    = 1'b0;
    u1      = 1'b0;
    u2      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          msg_d   = data_i;
          r1_d    = 2'b00;
          r2_d    = 2'b00;
          idx_d   = '0;
          state_d = S_ENC;
        end
      end
      S_ENC: begin
        step = 1'b1;
        u1   = msg_q[3'd4 - idx_q];
        u2   = msg_q[3'd4 - pi_f(idx_q)];
        if (idx_q == IDX_W'(INPUT_SIZE - 1)) begin
          idx_d   = '0;
          state_d = S_TAIL;
        end else begin
          idx_d = idx_q + 3'd1;
        end
      end
      S_TAIL: begin
        // u = s1 ^ s2 drives the feedback sum to zero, flushing the state.
        step = 1'b1;
        u1   = r1_q[1] ^ r1_q[0];
        u2   = r2_q[1] ^ r2_q[0];
        if (idx_q == 3'd1) begin
          idx_d   = '0;
          state_d = S_DONE;
        end else begin
          idx_d = 3'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    a1   = u1 ^ r1_q[1] ^ r1_q[0];
    a2   = u2 ^ r2_q[1] ^ r2_q[0];
    par1 = a1 ^ r1_q[0];
    par2 = a2 ^ r2_q[0];

    if (step) begin
      r1_d  = {a1, r1_q[1]};
      r2_d  = {a2, r2_q[1]};
      sys_d = {sys_q[EXTEND_SIZE-2:0], u1};
      p1_d  = {p1_q[EXTEND_SIZE-2:0], par1};
      p2_d  = {p2_q[EXTEND_SIZE-2:0], par2};
    end

    if (state_d == S_DONE) begin
      data_d = {sys_d, p1_d, p2_d};
    end

    done_d = (state_d == S_DONE);
    busy_d = (state_d != S_IDLE);

`ifdef TURBO_ENC_FRAME_CNT_EN
    cnt_d = (state_d == S_DONE) ? cnt_q + 8'd1 : cnt_q;
`endif
  end

  // State and output registers.
  always_ff @(posedge clk_p_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      msg_q   <= '0;
      r1_q    <= '0;
      r2_q    <= '0;
      sys_q   <= '0;
      p1_q    <= '0;
      p2_q    <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
`ifdef TURBO_ENC_FRAME_CNT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      msg_q   <= msg_d;
      r1_q    <= r1_d;
      r2_q    <= r2_d;
      sys_q   <= sys_d;
      p1_q    <= p1_d;
      p2_q    <= p2_d;
      data_q  <= data_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
`ifdef TURBO_ENC_FRAME_CNT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign data_o = data_q;
  assign done_o = done_q;
  assign busy_o = busy_q;
`ifdef TURBO_ENC_FRAME_CNT_EN
  assign frame_cnt_o = cnt_q;
`endif

endmodule
